// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_LOCK0 = 2'd1,
        ARB_LOCK1 = 2'd2
    } arb_state_e;

    typedef logic req_id_t;

    localparam int unsigned STATS_W   = 16;
    localparam int unsigned TO_CNT_W  = 8;
    localparam int unsigned TO_STAT_W = 8;

    // One in-flight read slot: whether a read was issued and who owns the return.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rd_return_tracker.sv
// Follows each issued read for RD_LATENCY cycles and steers the returned data
// to the requester that issued it.
module rd_return_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_issue,
    input  logic                  i_issue_id,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic                  o_rvalid0,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic                  o_rvalid1
);

    rd_tag_t [RD_LATENCY-1:0] tag_q;
    rd_tag_t                  tail;

    assign tail = tag_q[RD_LATENCY-1];

    // Tag pipeline lines up with the controller's read latency.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= '{valid: i_issue, id: i_issue_id};
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata0  <= '0;
            o_rvalid0 <= 1'b0;
            o_rdata1  <= '0;
            o_rvalid1 <= 1'b0;
        end else begin
            o_rvalid0 <= tail.valid & (tail.id == 1'b0);
            o_rvalid1 <= tail.valid & (tail.id == 1'b1);
            if (tail.valid && (tail.id == 1'b0)) o_rdata0 <= i_rd_data;
            if (tail.valid && (tail.id == 1'b1)) o_rdata1 <= i_rd_data;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with
// burst lock, idle lock timeout and read-return routing. ARB_STATS_EN adds grant/timeout counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
`ifdef ARB_STATS_EN
    input  logic                  i_stats_clr,
    output logic [STATS_W-1:0]    o_gnt_cnt0,
    output logic [STATS_W-1:0]    o_gnt_cnt1,
    output logic [TO_STAT_W-1:0]  o_lock_timeouts,
`endif
    input  logic                  i_req0,
    input  logic                  i_wr0,
    input  logic                  i_lock0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_wdata0,
    output logic                  o_gnt0,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    output logic                  o_rvalid0,
    input  logic                  i_req1,
    input  logic                  i_wr1,
    input  logic                  i_lock1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_wdata1,
    output logic                  o_gnt1,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic                  o_rvalid1,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic [DATA_WIDTH-1:0] i_rd_data
);

    arb_state_e            state_q, state_d;
    req_id_t               rr_q;
    logic [TO_CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                  gnt0, gnt1, acc0, acc1, acc;
    logic                  own_req, timeout_hit;
    req_id_t               win_id, rd_id_q;
    logic                  win_wr, win_lock;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // Grant selection, lock ownership and idle-timeout release.
    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        own_req     = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                gnt0       = i_req0 & (~i_req1 | (rr_q == 1'b0));
                gnt1       = i_req1 & (~i_req0 | (rr_q == 1'b1));
                idle_cnt_d = '0;
            end
            ARB_LOCK0, ARB_LOCK1: begin
                own_req = (state_q == ARB_LOCK1) ? i_req1 : i_req0;
                gnt0    = (state_q == ARB_LOCK0) & i_req0;
                gnt1    = (state_q == ARB_LOCK1) & i_req1;
                if (own_req) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == TO_CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d     = ARB_IDLE;
                    idle_cnt_d  = '0;
                    timeout_hit = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_CNT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        gnt0      = gnt0 & i_reset_n;
        gnt1      = gnt1 & i_reset_n;
        acc0      = i_req0 & gnt0;
        acc1      = i_req1 & gnt1;
        acc       = acc0 | acc1;
        win_id    = acc1;
        win_wr    = acc1 ? i_wr1    : i_wr0;
        win_lock  = acc1 ? i_lock1  : i_lock0;
        win_addr  = acc1 ? i_addr1  : i_addr0;
        win_wdata = acc1 ? i_wdata1 : i_wdata0;
        if (acc) begin
            state_d = win_lock ? (acc1 ? ARB_LOCK1 : ARB_LOCK0) : ARB_IDLE;
        end
    end

    assign o_gnt0 = gnt0;
    assign o_gnt1 = gnt1;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ARB_IDLE;
            idle_cnt_q <= '0;
            rr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            if (acc) rr_q <= ~win_id;
        end
    end

    // Command register: a beat is presented for exactly one cycle after its accept.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
            o_address <= '0;
            o_wr_data <= '0;
            rd_id_q   <= 1'b0;
        end else begin
            o_wr_en   <= acc & win_wr;
            o_rd_en   <= acc & ~win_wr;
            o_address <= acc ? win_addr : '0;
            o_wr_data <= (acc & win_wr) ? win_wdata : '0;
            rd_id_q   <= acc ? win_id : 1'b0;
        end
    end

    rd_return_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_return_tracker (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_issue    (o_rd_en),
        .i_issue_id (rd_id_q),
        .i_rd_data  (i_rd_data),
        .o_rdata0   (o_rdata0),
        .o_rvalid0  (o_rvalid0),
        .o_rdata1   (o_rdata1),
        .o_rvalid1  (o_rvalid1)
    );

`ifdef ARB_STATS_EN
    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_gnt_cnt0      <= '0;
            o_gnt_cnt1      <= '0;
            o_lock_timeouts <= '0;
        end else if (i_stats_clr) begin
            o_gnt_cnt0      <= '0;
            o_gnt_cnt1      <= '0;
            o_lock_timeouts <= '0;
        end else begin
            if (acc0 && (o_gnt_cnt0 != '1)) o_gnt_cnt0 <= o_gnt_cnt0 + STATS_W'(1);
            if (acc1 && (o_gnt_cnt1 != '1)) o_gnt_cnt1 <= o_gnt_cnt1 + STATS_W'(1);
            if (timeout_hit && (o_lock_timeouts != '1)) begin
                o_lock_timeouts <= o_lock_timeouts + TO_STAT_W'(1);
            end
        end
    end
`endif

endmodule
